// File: rtl/execute_stage.sv
// EX stage of the RV32IM pipeline: operand forwarding, ALU, multiplier, branch
// resolution, an iterative restoring divider, and the EX/MEM pipeline register.
module execute_stage #(
    parameter bit DIV_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] OP1E,
    input  logic [31:0] OP2E,
    input  logic [31:0] IMME,
    input  logic [31:0] PCE,
    input  logic [31:0] InstructionE,
    input  logic [4:0]  RDE,
    input  logic [1:0]  fwdA,
    input  logic [1:0]  fwdB,
    input  logic [31:0] WBDataW,
    input  logic        ASelE,
    input  logic        BSelE,
    input  logic [3:0]  ALUCtrlE,
    input  logic        MulDivE,
    input  logic [2:0]  BrTypeE,
    input  logic        JalrE,
    input  logic        w_enE,
    input  logic        wd_enE,
    input  logic        rd_enE,
    input  logic [2:0]  op_selE,
    input  logic [1:0]  WBSelE,
    input  logic        killE,
    output logic        stallE,
    output logic        BrTakenE,
    output logic [31:0] BrTargetE,
    output logic [31:0] OP2M,
    output logic [31:0] PCM_4,
    output logic [31:0] ALU_OpM,
    output logic [31:0] Instruction_Mem,
    output logic        w_enM,
    output logic        wd_enM,
    output logic        rd_enM,
    output logic [2:0]  op_selM,
    output logic [1:0]  WBSelM,
    output logic [4:0]  RDM,
    output logic [1:0]  dbg_div_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    div_state_t  state;
    logic [5:0]  count;
    logic [31:0] quo, rem, dvs;
    logic [31:0] div_a, div_b;
    logic [1:0]  div_op;

    logic [31:0] a_fwd, b_fwd, a_op, b_op;
    logic [4:0]  shamt;
    logic [31:0] alu_res, mul_res, div_res, ex_result;
    logic [63:0] mul_a, mul_b, prod;
    logic        mul_a_signed, mul_b_signed;
    logic        br_cmp, div_start, start_signed;
    logic [31:0] a_abs_in, b_abs_in, jalr_sum;
    logic [32:0] rem_shift, diff;
    logic [31:0] q_fix, r_fix;

    always_comb begin
        case (fwdA)
            2'b01:   a_fwd = ALU_OpM;
            2'b10:   a_fwd = WBDataW;
            default: a_fwd = OP1E;
        endcase
        case (fwdB)
            2'b01:   b_fwd = ALU_OpM;
            2'b10:   b_fwd = WBDataW;
            default: b_fwd = OP2E;
        endcase
    end

    assign a_op  = ASelE ? PCE : a_fwd;
    assign b_op  = BSelE ? IMME : b_fwd;
    assign shamt = b_op[4:0];

    always_comb begin
        case (ALUCtrlE)
            4'd0:    alu_res = a_op + b_op;
            4'd1:    alu_res = a_op - b_op;
            4'd2:    alu_res = a_op << shamt;
            4'd3:    alu_res = {31'd0, $signed(a_op) < $signed(b_op)};
            4'd4:    alu_res = {31'd0, a_op < b_op};
            4'd5:    alu_res = a_op ^ b_op;
            4'd6:    alu_res = a_op >> shamt;
            4'd7:    alu_res = $unsigned($signed(a_op) >>> shamt);
            4'd8:    alu_res = a_op | b_op;
            4'd9:    alu_res = a_op & b_op;
            4'd10:   alu_res = b_op;
            default: alu_res = 32'd0;
        endcase
    end

    // Sign-extending to 64 bits lets one unsigned multiply serve all variants.
    assign mul_a_signed = (op_selE == 3'd1) || (op_selE == 3'd2);
    assign mul_b_signed = (op_selE == 3'd1);
    assign mul_a   = {{32{mul_a_signed & a_fwd[31]}}, a_fwd};
    assign mul_b   = {{32{mul_b_signed & b_fwd[31]}}, b_fwd};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op_selE == 3'd0) ? prod[31:0] : prod[63:32];

    always_comb begin
        case (BrTypeE)
            3'd1:    br_cmp = (a_fwd == b_fwd);
            3'd2:    br_cmp = (a_fwd != b_fwd);
            3'd3:    br_cmp = ($signed(a_fwd) < $signed(b_fwd));
            3'd4:    br_cmp = ($signed(a_fwd) >= $signed(b_fwd));
            3'd5:    br_cmp = (a_fwd < b_fwd);
            3'd6:    br_cmp = (a_fwd >= b_fwd);
            default: br_cmp = 1'b0;
        endcase
    end

    assign jalr_sum  = a_fwd + IMME;
    assign BrTakenE  = (br_cmp | (BrTypeE == 3'd7)) & ~killE;
    assign BrTargetE = JalrE ? (jalr_sum & 32'hFFFF_FFFE) : (PCE + IMME);

    // Divider: funct3[0]=1 selects unsigned, funct3[1]=1 selects remainder.
    assign div_start    = MulDivE & op_selE[2] & ~killE & DIV_EN;
    assign start_signed = ~op_selE[0];
    assign a_abs_in     = (start_signed & a_fwd[31]) ? (32'd0 - a_fwd) : a_fwd;
    assign b_abs_in     = (start_signed & b_fwd[31]) ? (32'd0 - b_fwd) : b_fwd;
    assign rem_shift    = {rem, quo[31]};
    assign diff         = rem_shift - {1'b0, dvs};

    always_comb begin
        q_fix = (~div_op[0] & (div_a[31] ^ div_b[31])) ? (32'd0 - quo) : quo;
        r_fix = (~div_op[0] & div_a[31]) ? (32'd0 - rem) : rem;
        if (div_b == 32'd0) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = div_a;
        end
        div_res = div_op[1] ? r_fix : q_fix;
    end

    always_comb begin
        ex_result = alu_res;
        if (MulDivE) begin
            if (op_selE[2]) ex_result = (DIV_EN && state == S_DONE) ? div_res : 32'd0;
            else            ex_result = mul_res;
        end
    end

    assign stallE        = rst & (((state == S_IDLE) & div_start) | (state == S_BUSY));
    assign dbg_div_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            count  <= 6'd0;
            quo    <= 32'd0;
            rem    <= 32'd0;
            dvs    <= 32'd0;
            div_a  <= 32'd0;
            div_b  <= 32'd0;
            div_op <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_start) begin
                        div_a  <= a_fwd;
                        div_b  <= b_fwd;
                        div_op <= op_selE[1:0];
                        quo    <= a_abs_in;
                        rem    <= 32'd0;
                        dvs    <= b_abs_in;
                        count  <= 6'd32;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (killE) begin
                        state <= S_IDLE;
                    end else begin
                        quo   <= {quo[30:0], ~diff[32]};
                        rem   <= diff[32] ? rem_shift[31:0] : diff[31:0];
                        count <= count - 6'd1;
                        if (count == 6'd1) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OP2M            <= 32'd0;
            PCM_4           <= 32'd0;
            ALU_OpM         <= 32'd0;
            Instruction_Mem <= 32'd0;
            w_enM           <= 1'b0;
            wd_enM          <= 1'b0;
            rd_enM          <= 1'b0;
            op_selM         <= 3'd0;
            WBSelM          <= 2'd0;
            RDM             <= 5'd0;
        end else begin
            OP2M    <= b_fwd;
            PCM_4   <= PCE + 32'd4;
            ALU_OpM <= ex_result;
            op_selM <= op_selE;
            WBSelM  <= WBSelE;
            if (stallE | killE) begin
                Instruction_Mem <= NOP_INSTR;
                w_enM           <= 1'b0;
                wd_enM          <= 1'b0;
                rd_enM          <= 1'b0;
                RDM             <= 5'd0;
            end else begin
                Instruction_Mem <= InstructionE;
                w_enM           <= w_enE;
                wd_enM          <= wd_enE;
                rd_enM          <= rd_enE;
                RDM             <= RDE;
            end
        end
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage RV32IM pipeline. It sits between the ID/EX register and the memory stage.
- It does the following:
  - resolves operand forwarding;
  - performs ALU, multiply and branch evaluation;
  - runs an iterative divider that stalls the front end;
  - registers all results into the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- DIV_EN, 1: 1 = iterative divider present. 0 = DIV/REM results are 0 with no stall.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- OP1E, OP2E  in  32 each  rs1/rs2 register-file values
- IMME  in  32  sign-extended immediate
- PCE  in  32  instruction PC
- InstructionE  in  32  instruction word
- RDE  in  5  destination register
- fwdA, fwdB  in  2 each  forwarding select: 00 regfile, 01 ALU_OpM, 10 WBDataW
- WBDataW  in  32  write-back value
- ASelE  in  1  A source: 0 forwarded rs1, 1 PCE
- BSelE  in  1  B source: 0 forwarded rs2, 1 IMME
- ALUCtrlE  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS-B
- MulDivE  in  1  M-extension op; op_selE selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (funct3 0..7)
- BrTypeE  in  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL/JALR
- JalrE  in  1  target from rs1+imm
- w_enE, wd_enE, rd_enE  in  1 each  control passed to EX/MEM
- op_selE  in  3  funct3
- WBSelE  in  2  write-back select
- killE  in  1  squash the current EX instruction
- stallE  out  1  hold IF/ID/ID-EX
- BrTakenE  out  1  redirect fetch
- BrTargetE  out  32  redirect target
- OP2M, PCM_4, ALU_OpM, Instruction_Mem  out  32 each  EX/MEM register
- w_enM, wd_enM, rd_enM  out  1 each  EX/MEM register
- op_selM  out  3  EX/MEM register
- WBSelM  out  2  EX/MEM register
- RDM  out  5  EX/MEM register

Behaviour:
- **Reset.** While rst low, all EX/MEM outputs are 0, the divider FSM is IDLE, and stallE=0.
- **Forwarding.** A/B forwarding is combinational from fwdA/fwdB; fwd=11 behaves as 00. OP2M takes forwarded rs2 (store data).
- **ALU.**
  - Shifts use B[4:0].
  - SLT is signed, SLTU unsigned.
  - Arithmetic wraps mod 2^32.
- **Multiply.** MUL* is single-cycle combinational on a 64-bit product:
  - MUL returns the low 32 bits;
  - MULH/MULHSU/MULHU return the high 32 bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- **Branch outcome.** BrTakenE = (compare true, or BrTypeE=7) and not killE.
- **Branch target.** BrTargetE = JalrE ? (A_fwd+IMME) & ~1 : PCE+IMME. PCM_4 = PCE+4.
- **Divider FSM, states IDLE, BUSY, DONE.** Fixed latency 34 cycles per divide.
  - **IDLE.** On MulDivE & op_selE[2] & ~killE & DIV_EN: latch the forwarded operands and the op, set counter=32, raise stallE, go to BUSY.
  - **BUSY.** One restoring quotient bit per cycle on absolute values; stallE=1; counter decrements; at 0 go to DONE.
  - **DONE.** Apply the sign fix-up; stallE=0; the result drives ALU_OpM at the next edge; return to IDLE.
  - **Divide by zero.** Quotient 0xFFFFFFFF, remainder = dividend.
  - **Signed overflow.** 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
  - Both special cases keep the 34-cycle latency.
- **EX/MEM register during stalls.**
  - While stallE=1, EX/MEM loads a bubble: w_enM=wd_enM=rd_enM=0, RDM=0, Instruction_Mem=0x00000013. ALU_OpM is don't-care.
  - Inputs are held by upstream during the stall. Divider operands come from latches only, so forwarding changes during BUSY are ignored.
- **Kill.** killE squashes the current instruction:
  - In IDLE or DONE, EX/MEM loads a bubble and BrTakenE=0.
  - In BUSY, the FSM aborts to IDLE next edge, stallE drops that edge, and a bubble is loaded.
- **Normal capture.** Otherwise every edge loads EX/MEM from the E-stage inputs and the computed result.

Test Plan:
- ADD with fwdA=01, ALU_OpM=5, OP2E=7, BSelE=0 -> ALU_OpM=12 next edge, w_enM follows w_enE.
- SRA 0x80000000 by IMME=4 (BSelE=1) -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. MULHU 0xFFFFFFFF² -> 0xFFFFFFFE.
- BLT, A=-1, B=1, PCE=0x100, IMME=0x20 -> BrTakenE=1, BrTargetE=0x120. JALR with A=0x201, IMME=2 -> target 0x202, PCM_4=PCE+4.
- DIV -7/2 -> stallE high 33 cycles, bubbles in EX/MEM, then ALU_OpM=-3. REM -7/2 -> -1. DIVU x/0 -> 0xFFFFFFFF. DIV 0x80000000/-1 -> 0x80000000.
- killE asserted at BUSY cycle 10 -> stallE low after next edge, FSM IDLE, bubble in EX/MEM. A following ADD completes normally.
- rst pulled low mid-divide -> all outputs 0, stallE=0 immediately. After release, the next DIV takes the full 34 cycles.
